instru_writer: RTL and testbench
================================

INSTRU_WRITER -- requirements
Module: instru_writer

Interface
REQ-001 Parameter ADDR_W, default 7, is the byte-address width of the instruction memory.
REQ-002 Parameter DEPTH, default 128, is the instruction memory depth in bytes, equal to 2**ADDR_W.
REQ-003 clk  input  1  sole clock; all state changes occur on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that arms a load session at base_addr.
REQ-006 base_addr  input  ADDR_W  first byte address of the session, sampled when start is accepted.
REQ-007 word_valid  input  1  the upstream source presents an instruction word.
REQ-008 word  input  32  instruction word; bits [31:24] are the most significant byte.
REQ-009 word_last  input  1  qualifies word as the final word of the session.
REQ-010 word_ready  output  1  the block accepts word on this cycle.
REQ-011 mem_we  output  1  byte write strobe to the instruction memory.
REQ-012 mem_addr  output  ADDR_W  byte address for mem_we.
REQ-013 mem_data  output  8  byte data for mem_we.
REQ-014 busy  output  1  a session is active (ARMED or WRITE).
REQ-015 done  output  1  the session completed normally; held until the next start or reset.
REQ-016 err  output  1  the session was aborted on an address overflow; held until the next start or reset.
REQ-017 word_count  output  ADDR_W-1  count of words fully written in the current session.

Function
REQ-018 The FSM states SHALL be IDLE, ARMED, WRITE, DONE and ERR.
REQ-019 IDLE, DONE, ERR: start=1 loads the pointer from base_addr, clears word_count, done and err, and moves to ARMED.
REQ-020 ARMED, pointer <= DEPTH-4: word_ready=1; word_valid=1 captures word and word_last, clears the beat counter, and moves to WRITE.
REQ-021 ARMED, pointer > DEPTH-4: word_ready=0 and the next state is ERR; no byte is written and there is no address wrap-around.
REQ-022 WRITE SHALL last exactly 4 cycles, with mem_we=1, mem_addr=pointer+beat and mem_data=captured byte[beat], where beat 0 is word[31:24] and beat 3 is word[7:0] (big-endian).
REQ-023 Latency: a handshake at cycle N gives mem_we=1 on cycles N+1 to N+4; word_ready=0 throughout WRITE; peak throughput is one word per 5 cycles.
REQ-024 At the end of beat 3: pointer += 4 and word_count += 1; the next state is DONE if the captured word_last=1, otherwise ARMED.
REQ-025 start SHALL be ignored in ARMED and WRITE.
REQ-026 word_valid outside ARMED SHALL be ignored and is not consumed.
REQ-027 Outside WRITE, mem_we=0, mem_addr=0 and mem_data=0.
REQ-028 busy=1 exactly in ARMED and WRITE; done=1 exactly in DONE; err=1 exactly in ERR.
REQ-029 Pointer arithmetic SHALL be performed ADDR_W+1 bits wide so that the overflow check in REQ-021 is exact.
REQ-030 All outputs SHALL be registered or decoded directly from state and registers, with no combinational path from inputs except word_ready from state and pointer.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, mem_we=0, mem_addr=0, mem_data=0, word_ready=0, busy=0, done=0, err=0 and word_count=0, including mid-WRITE.
REQ-032 A word interrupted by reset SHALL be neither completed nor counted.
REQ-033 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-034 A shared package SHALL hold the state enumeration, ADDR_W, DEPTH and the bytes-per-word constant 4.
REQ-035 The block SHALL be self-contained with no sub-module.
REQ-036 The byte memory, written through mem_*, is external to the block.

Verification
REQ-037 Single word: start with base_addr=0, then word=32'hA1B2C3D4 with word_last=1 -> writes A1@0, B2@1, C3@2, D4@3 on cycles N+1 to N+4; done=1 and word_count=1.
REQ-038 Stream: 3 words back-to-back from base 8 with word_valid held high -> handshakes 5 cycles apart, bytes at addresses 8 to 19, done after the third word.
REQ-039 Overflow: base_addr=124, two words with no word_last -> the first word is written to 124..127, the second is never accepted, err=1 and word_count=1.
REQ-040 Unaligned end: base_addr=125, one word -> no mem_we at all and err=1.
REQ-041 Reset on beat 2 -> mem_we drops asynchronously, state is IDLE, word_count=0, and a following start at base 0 works normally.
REQ-042 start pulsed during WRITE and word_valid held in IDLE -> both ignored, with no stray writes.

Source files
------------

// File: rtl/instru_writer_pkg.sv
// rtl/instru_writer_pkg.sv - shared constants and FSM state type for instru_writer
//
// Purpose: default memory geometry, bytes-per-word and the session state
// enumeration shared by the instruction writer and anything that talks to it.
package instru_writer_pkg;

  localparam int ADDR_W         = 7;
  localparam int DEPTH          = 2 ** ADDR_W;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/instru_writer.sv
// rtl/instru_writer.sv - unpacks 32-bit instruction words into big-endian byte writes
//
// Purpose: a load session is armed by start at base_addr; each accepted word
// is written as four consecutive bytes (MSB first) over four cycles. The
// session ends in DONE after a word flagged word_last, or in ERR when the next
// word would run past the end of memory.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, base_addr   arm a session at base_addr (ignored while busy)
//   word_valid, word,  upstream word source; accepted when word_ready=1
//   word_last, word_ready
//   mem_we, mem_addr,  byte write port to the external instruction memory
//   mem_data
//   busy, done, err    session status decoded from state
//   word_count         words fully written in the current session
module instru_writer #(
  parameter int ADDR_W = instru_writer_pkg::ADDR_W,
  parameter int DEPTH  = instru_writer_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  input  logic [31:0]       word,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] word_count
);
  import instru_writer_pkg::*;

  // Pointer carries one extra bit so that base+4*n past the top of memory is
  // visible as a large value instead of wrapping back to a low address.
  localparam logic [ADDR_W:0]   LAST_WORD_PTR = (ADDR_W+1)'(DEPTH - BYTES_PER_WORD);
  localparam logic [ADDR_W:0]   PTR_STEP      = (ADDR_W+1)'(BYTES_PER_WORD);
  localparam logic [ADDR_W-2:0] COUNT_ONE     = (ADDR_W-1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [ADDR_W-2:0] count_q, count_d;

  logic              room;

  assign room = (ptr_q <= LAST_WORD_PTR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_ARMED;
          ptr_d   = {1'b0, base_addr};
          count_d = '0;
        end
      end
      ST_ARMED: begin
        if (!room) begin
          // Not enough bytes left for a whole word: abort without writing.
          state_d = ST_ERR;
        end else if (word_valid) begin
          state_d = ST_WRITE;
          word_d  = word;
          last_d  = word_last;
          beat_d  = 2'd0;
        end
      end
      ST_WRITE: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          ptr_d   = ptr_q + PTR_STEP;
          count_d = count_q + COUNT_ONE;
          state_d = last_q ? ST_DONE : ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and registers; word_ready is the only one that
  // also looks at the pointer.
  always_comb begin
    word_ready = (state_q == ST_ARMED) && room;
    busy       = (state_q == ST_ARMED) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    err        = (state_q == ST_ERR);
    word_count = count_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = 8'h00;
    if (state_q == ST_WRITE) begin
      mem_we   = 1'b1;
      mem_addr = ptr_q[ADDR_W-1:0] + ADDR_W'(beat_q);
      case (beat_q)
        2'd0:    mem_data = word_q[31:24];
        2'd1:    mem_data = word_q[23:16];
        2'd2:    mem_data = word_q[15:8];
        default: mem_data = word_q[7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_instru_writer.sv
// tb/tb_instru_writer.sv - directed self-checking bench for instru_writer
module tb_instru_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  base_addr = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word = '0;
  logic        word_last = 1'b0;
  logic        word_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        busy, done, err;
  logic [5:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  logic [7:0] tb_mem [0:127];

  instru_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_valid(word_valid), .word(word), .word_last(word_last),
    .word_ready(word_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory model fed from the write port, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [6:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({mem_we, mem_addr, mem_data, word_ready, busy, done, err, word_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h rdy=%0b busy=%0b done=%0b err=%0b cnt=%0d, want all 0",
               mem_we, mem_addr, mem_data, word_ready, busy, done, err, word_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    arm(7'd0);
    n_checks++;
    if (busy !== 1'b1 || word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_armed: busy=%0b ready=%0b, want 1 1", busy, word_ready);
    end
    word_valid = 1'b1; word = 32'hA1B2C3D4; word_last = 1'b1;
    tick();
    word_valid = 1'b0; word_last = 1'b0;
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 7'(b) || mem_data !== exp_b[b] || word_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_beat%0d: we=%0b addr=%0d data=%h rdy=%0b, want 1 %0d %h 0",
                 b, mem_we, mem_addr, mem_data, word_ready, b, exp_b[b]);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || word_count !== 6'd1 || mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL single_done: done=%0b cnt=%0d we=%0b busy=%0b addr=%0d, want 1 1 0 0 0",
               done, word_count, mem_we, busy, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [7:0]  exp_bytes [12];
    int hs_cyc [3];
    int w0;
    words = '{32'h00112233, 32'h44556677, 32'h8899AABB};
    exp_bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                  8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    w0 = wr_cnt;
    arm(7'd8);
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word = words[i];
      word_last = (i == 2);
      n_checks++;
      if (word_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready%0d: ready=%0b, want 1", i, word_ready);
      end
      tick();
      hs_cyc[i] = cyc;
      for (int b = 0; b < 4; b++) begin
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 7'(8 + 4*i + b) || mem_data !== exp_bytes[4*i+b]) begin
          n_fail++;
          $display("FAIL stream_w%0d_b%0d: we=%0b addr=%0d data=%h, want 1 %0d %h",
                   i, b, mem_we, mem_addr, mem_data, 8 + 4*i + b, exp_bytes[4*i+b]);
        end
        tick();
      end
    end
    word_valid = 1'b0; word_last = 1'b0;
    n_checks++;
    if (hs_cyc[1] - hs_cyc[0] !== 5 || hs_cyc[2] - hs_cyc[1] !== 5) begin
      n_fail++;
      $display("FAIL stream_spacing: gaps %0d %0d, want 5 5", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]);
    end
    n_checks++;
    if (done !== 1'b1 || word_count !== 6'd3) begin
      n_fail++;
      $display("FAIL stream_done: done=%0b cnt=%0d, want 1 3", done, word_count);
    end
    n_checks++;
    if (wr_cnt - w0 !== 12 || tb_mem[8] !== 8'h00 || tb_mem[13] !== 8'h55 || tb_mem[19] !== 8'hBB) begin
      n_fail++;
      $display("FAIL stream_mem: writes=%0d m8=%h m13=%h m19=%h, want 12 00 55 bb",
               wr_cnt - w0, tb_mem[8], tb_mem[13], tb_mem[19]);
    end
  endtask

  task automatic test_overflow();
    int w0;
    w0 = wr_cnt;
    arm(7'd124);
    word_valid = 1'b1; word = 32'hDEADBEEF; word_last = 1'b0;
    tick();
    word = 32'h01020304;
    repeat (4) tick();
    n_checks++;
    if (word_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_armed: ready=%0b busy=%0b, want 0 1", word_ready, busy);
    end
    tick();
    word_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0 || word_count !== 6'd1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_err: err=%0b done=%0b cnt=%0d busy=%0b, want 1 0 1 0", err, done, word_count, busy);
    end
    repeat (3) tick();
    n_checks++;
    if (wr_cnt - w0 !== 4 || tb_mem[124] !== 8'hDE || tb_mem[127] !== 8'hEF || tb_mem[0] !== 8'hA1) begin
      n_fail++;
      $display("FAIL ovf_mem: writes=%0d m124=%h m127=%h m0=%h, want 4 de ef a1",
               wr_cnt - w0, tb_mem[124], tb_mem[127], tb_mem[0]);
    end
  endtask

  task automatic test_unaligned_end();
    int w0;
    w0 = wr_cnt;
    arm(7'd125);
    word_valid = 1'b1; word = 32'hCAFEF00D; word_last = 1'b1;
    n_checks++;
    if (word_ready !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL unal_armed: ready=%0b err=%0b, want 0 0", word_ready, err);
    end
    tick();
    repeat (3) tick();
    word_valid = 1'b0; word_last = 1'b0;
    n_checks++;
    if (err !== 1'b1 || word_count !== 6'd0 || wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL unal_err: err=%0b cnt=%0d writes=%0d, want 1 0 0", err, word_count, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_midwrite();
    arm(7'd0);
    word_valid = 1'b1; word = 32'h55667788; word_last = 1'b1;
    tick();
    word_valid = 1'b0; word_last = 1'b0;
    tick();
    tick();
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd2 || mem_data !== 8'h77) begin
      n_fail++;
      $display("FAIL rst_beat2: we=%0b addr=%0d data=%h, want 1 2 77", mem_we, mem_addr, mem_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, mem_addr, mem_data, busy, done, err, word_count, word_ready} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: we=%0b addr=%0d data=%h busy=%0b done=%0b err=%0b cnt=%0d rdy=%0b, want all 0",
               mem_we, mem_addr, mem_data, busy, done, err, word_count, word_ready);
    end
    #1;
    rst_n = 1'b1;
    arm(7'd0);
    n_checks++;
    if (busy !== 1'b1 || word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first_start: busy=%0b ready=%0b, want 1 1", busy, word_ready);
    end
    word_valid = 1'b1; word = 32'h0A0B0C0D; word_last = 1'b1;
    tick();
    word_valid = 1'b0; word_last = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || word_count !== 6'd1 || tb_mem[0] !== 8'h0A || tb_mem[2] !== 8'h0C || tb_mem[3] !== 8'h0D) begin
      n_fail++;
      $display("FAIL rst_restart: done=%0b cnt=%0d m0=%h m2=%h m3=%h, want 1 1 0a 0c 0d",
               done, word_count, tb_mem[0], tb_mem[2], tb_mem[3]);
    end
  endtask

  task automatic test_ignored_inputs();
    int w0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    w0 = wr_cnt;
    word_valid = 1'b1; word = 32'h11223344; word_last = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || word_ready !== 1'b0 || wr_cnt - w0 !== 0) begin
      n_fail++;
      $display("FAIL idle_valid: busy=%0b we=%0b rdy=%0b writes=%0d, want 0 0 0 0",
               busy, mem_we, word_ready, wr_cnt - w0);
    end
    arm(7'd16);
    tick();
    word_valid = 1'b0; word_last = 1'b0;
    tick();
    base_addr = 7'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 7'd18 || mem_data !== 8'h33) begin
      n_fail++;
      $display("FAIL write_start: we=%0b addr=%0d data=%h, want 1 18 33", mem_we, mem_addr, mem_data);
    end
    repeat (2) tick();
    n_checks++;
    if (done !== 1'b1 || word_count !== 6'd1 || wr_cnt - w0 !== 4 || tb_mem[16] !== 8'h11 || tb_mem[19] !== 8'h44) begin
      n_fail++;
      $display("FAIL ignored_done: done=%0b cnt=%0d writes=%0d m16=%h m19=%h, want 1 1 4 11 44",
               done, word_count, wr_cnt - w0, tb_mem[16], tb_mem[19]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_unaligned_end();
    test_reset_midwrite();
    test_ignored_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
